mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter AW, default 12: SRAM word-address width.
REQ-002 Parameter WAIT_STATES, default 1, legal range 1..15: number of cycles after the SRAM enable cycle before read data is sampled.
REQ-003 Port iClk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port nRst, input, 1: one clock; reset is asynchronous and active-low.
REQ-005 Port iMemIRead, input, 1: instruction fetch request, held high until oRdy.
REQ-006 Port iMemDRead, input, 1: data read request, held high until oRdy.
REQ-007 Port iMemDWrite, input, 1: data write request, held high until oRdy.
REQ-008 Port iAddrI, input, 32: instruction byte address.
REQ-009 Port iAddrD, input, 32: data byte address.
REQ-010 Port iWData, input, 32: write data.
REQ-011 Port oIns, output, 32: last fetched instruction word.
REQ-012 Port oRData, output, 32: last data read word.
REQ-013 Port oRdy, output, 1: one-cycle completion pulse; this pulse drives the control unit's iRdy.
REQ-014 Port oFault, output, 1: one-cycle pulse, coincident with oRdy, that flags an aborted request.
REQ-015 Ports oSramCe (1), oSramWe (1), oSramAddr (AW), oSramWData (32), iSramRData (32): synchronous single-port SRAM interface.

Function
REQ-016 FSM states: IDLE, ACCESS, WAIT, DONE; all outputs are registered.
REQ-017 IDLE, any request high at the rising edge: latch op, word address (addr[AW+1:2]) and write data; go to ACCESS, or to DONE with fault set if the request is illegal.
REQ-018 Priority is data over instruction: with iMemIRead and a data request both high, the data request is served and the fetch waits in IDLE for a later cycle.
REQ-019 Illegal request: latched addr[1:0] != 0, or iMemDRead and iMemDWrite both high; no SRAM access, oFault=1 and oRdy=1 in DONE, oIns and oRData unchanged.
REQ-020 ACCESS, exactly one cycle: oSramCe=1, oSramWe=1 only for a write, oSramAddr and oSramWData hold the latched values; next state WAIT with the wait counter loaded to WAIT_STATES-1.
REQ-021 WAIT: oSramCe=0; the counter decrements each cycle.
REQ-022 WAIT, counter == 0 at the edge: a read loads iSramRData into oIns (fetch) or oRData (data read); next state DONE.
REQ-023 DONE, exactly one cycle: oRdy=1; next state always IDLE.
REQ-024 A request still held in the IDLE cycle after DONE is treated as a new request.
REQ-025 Latency: request sampled at the end of cycle N gives oRdy high in cycle N+2+WAIT_STATES; illegal requests give oRdy high in cycle N+1.
REQ-026 A request deasserted after it is latched does not abort the access; the transaction completes and oRdy still pulses.
REQ-027 iAddr, iWData and request-type changes after latching are ignored until the next IDLE sample.
REQ-028 oIns and oRData hold their values between their respective read completions; a write never changes either output.
REQ-029 Address bits above AW+1 are ignored; there is no wrap detection.

Reset
REQ-030 nRst low forces, asynchronously: state=IDLE, counter=0, oRdy=0, oFault=0, oSramCe=0, oSramWe=0, oSramAddr=0, oSramWData=0, oIns=0, oRData=0.
REQ-031 Reset asserted mid-transaction aborts it with no oRdy pulse and oSramCe/oSramWe deasserted immediately.
REQ-032 After nRst rises, the first request is sampled at the first rising edge with nRst high.

Verification
REQ-033 WAIT_STATES=1, SRAM[0x10]=0xDEADBEEF, iMemIRead=1, iAddrI=0x40 sampled at end of cycle 0 -> oSramCe=1 with addr 0x10 in cycle 1, oRdy=1 and oIns=0xDEADBEEF in cycle 3.
REQ-034 Write iAddrD=0x8, iWData=0x12345678, then a read of 0x8 -> oSramWe=1 only in the write's ACCESS cycle, oRData=0x12345678 on the read's oRdy, oIns unchanged.
REQ-035 iMemIRead and iMemDRead raised in the same cycle -> data read completes first (oRdy, oRData valid), then the fetch completes WAIT_STATES+2 cycles after its own sample.
REQ-036 iMemDRead=1 with iAddrD=0x6 -> oRdy=1 and oFault=1 in the next cycle, oSramCe never asserted, oRData unchanged.
REQ-037 nRst pulled low during WAIT (WAIT_STATES=3) -> all outputs 0 immediately, no oRdy; after release, a new fetch completes with normal latency.
REQ-038 WAIT_STATES=4, back-to-back held fetches -> oRdy pulses every 7 cycles, each sampling the SRAM exactly 4 cycles after its ACCESS cycle.

Source files
------------

// File: rtl/mem_responder.sv
// Purpose : serves instruction-fetch and data read/write requests from a synchronous single-port SRAM.
// Latency : oRdy is high WAIT_STATES+2 cycles after the request is sampled, or 1 cycle for an illegal request.
// Backpres: the requester holds its request until oRdy; only one request is in flight, and data wins over fetch.
//
// Ports:
//   iClk, nRst                          clock, asynchronous active-low reset
//   iMemIRead / iMemDRead / iMemDWrite  request strobes, held until oRdy
//   iAddrI, iAddrD, iWData              byte addresses and write data, latched in IDLE
//   oIns, oRData                        last fetched instruction / last data read word
//   oRdy, oFault                        one-cycle completion pulse; oFault flags an aborted request
//   oSramCe/We/Addr/WData, iSramRData   SRAM port (word address)
module mem_responder #(
    parameter int AW          = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic          iClk,
    input  logic          nRst,
    input  logic          iMemIRead,
    input  logic          iMemDRead,
    input  logic          iMemDWrite,
    input  logic [31:0]   iAddrI,
    input  logic [31:0]   iAddrD,
    input  logic [31:0]   iWData,
    output logic [31:0]   oIns,
    output logic [31:0]   oRData,
    output logic          oRdy,
    output logic          oFault,
    output logic          oSramCe,
    output logic          oSramWe,
    output logic [AW-1:0] oSramAddr,
    output logic [31:0]   oSramWData,
    input  logic [31:0]   iSramRData
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES - 1);

    state_t        state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          op_write, op_write_nxt;
    logic          op_fetch, op_fetch_nxt;
    logic          rdy_nxt, fault_nxt;
    logic          sram_ce_nxt, sram_we_nxt;
    logic [AW-1:0] sram_addr_nxt;
    logic [31:0]   sram_wdata_nxt;
    logic [31:0]   ins_nxt, rdata_nxt;

    logic data_req;
    logic data_illegal;
    logic fetch_illegal;

    // Upper address bits fall outside the SRAM and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{iAddrI[31:AW+2], iAddrD[31:AW+2]};

    assign data_req      = iMemDRead | iMemDWrite;
    assign data_illegal  = (iAddrD[1:0] != 2'b00) | (iMemDRead & iMemDWrite);
    assign fetch_illegal = (iAddrI[1:0] != 2'b00);

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            state      <= S_IDLE;
            cnt        <= 4'd0;
            op_write   <= 1'b0;
            op_fetch   <= 1'b0;
            oRdy       <= 1'b0;
            oFault     <= 1'b0;
            oSramCe    <= 1'b0;
            oSramWe    <= 1'b0;
            oSramAddr  <= '0;
            oSramWData <= 32'd0;
            oIns       <= 32'd0;
            oRData     <= 32'd0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            op_write   <= op_write_nxt;
            op_fetch   <= op_fetch_nxt;
            oRdy       <= rdy_nxt;
            oFault     <= fault_nxt;
            oSramCe    <= sram_ce_nxt;
            oSramWe    <= sram_we_nxt;
            oSramAddr  <= sram_addr_nxt;
            oSramWData <= sram_wdata_nxt;
            oIns       <= ins_nxt;
            oRData     <= rdata_nxt;
        end
    end

    // Every output is registered, so this block computes the value each
    // output takes in the *next* cycle alongside the next state.
    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        op_write_nxt   = op_write;
        op_fetch_nxt   = op_fetch;
        rdy_nxt        = 1'b0;
        fault_nxt      = 1'b0;
        sram_ce_nxt    = 1'b0;
        sram_we_nxt    = 1'b0;
        sram_addr_nxt  = oSramAddr;
        sram_wdata_nxt = oSramWData;
        ins_nxt        = oIns;
        rdata_nxt      = oRData;

        case (state)
            S_IDLE: begin
                if (data_req) begin
                    op_write_nxt   = iMemDWrite;
                    op_fetch_nxt   = 1'b0;
                    sram_addr_nxt  = iAddrD[AW+1:2];
                    sram_wdata_nxt = iWData;
                    if (data_illegal) begin
                        state_nxt = S_DONE;
                        rdy_nxt   = 1'b1;
                        fault_nxt = 1'b1;
                    end else begin
                        state_nxt   = S_ACCESS;
                        sram_ce_nxt = 1'b1;
                        sram_we_nxt = iMemDWrite;
                    end
                end else if (iMemIRead) begin
                    op_write_nxt  = 1'b0;
                    op_fetch_nxt  = 1'b1;
                    sram_addr_nxt = iAddrI[AW+1:2];
                    if (fetch_illegal) begin
                        state_nxt = S_DONE;
                        rdy_nxt   = 1'b1;
                        fault_nxt = 1'b1;
                    end else begin
                        state_nxt   = S_ACCESS;
                        sram_ce_nxt = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                state_nxt = S_WAIT;
                cnt_nxt   = WAIT_LOAD;
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_DONE;
                    rdy_nxt   = 1'b1;
                    if (!op_write) begin
                        if (op_fetch) begin
                            ins_nxt = iSramRData;
                        end else begin
                            rdata_nxt = iSramRData;
                        end
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: WAIT_STATES=1, instance 1: WAIT_STATES=3, instance 2: WAIT_STATES=4
    logic        nrst [3];
    logic        ird  [3];
    logic        drd  [3];
    logic        dwr  [3];
    logic [31:0] addr_i;
    logic [31:0] addr_d;
    logic [31:0] wdat;

    logic [31:0] ins   [3];
    logic [31:0] rdat  [3];
    logic        rdy   [3];
    logic        flt   [3];
    logic        ce    [3];
    logic        we    [3];
    logic [11:0] saddr [3];
    logic [31:0] swd   [3];
    logic [31:0] srd   [3];

    logic [31:0] mem [3][4096];

    // Preload port into the SRAM model, used only while the DUTs are in reset.
    logic        pl_vld;
    int          pl_k;
    logic [11:0] pl_a;
    logic [31:0] pl_d;

    int checks   = 0;
    int failures = 0;

    mem_responder #(.AW(12), .WAIT_STATES(1)) u_ws1 (
        .iClk(clk), .nRst(nrst[0]),
        .iMemIRead(ird[0]), .iMemDRead(drd[0]), .iMemDWrite(dwr[0]),
        .iAddrI(addr_i), .iAddrD(addr_d), .iWData(wdat),
        .oIns(ins[0]), .oRData(rdat[0]), .oRdy(rdy[0]), .oFault(flt[0]),
        .oSramCe(ce[0]), .oSramWe(we[0]), .oSramAddr(saddr[0]),
        .oSramWData(swd[0]), .iSramRData(srd[0])
    );

    mem_responder #(.AW(12), .WAIT_STATES(3)) u_ws3 (
        .iClk(clk), .nRst(nrst[1]),
        .iMemIRead(ird[1]), .iMemDRead(drd[1]), .iMemDWrite(dwr[1]),
        .iAddrI(addr_i), .iAddrD(addr_d), .iWData(wdat),
        .oIns(ins[1]), .oRData(rdat[1]), .oRdy(rdy[1]), .oFault(flt[1]),
        .oSramCe(ce[1]), .oSramWe(we[1]), .oSramAddr(saddr[1]),
        .oSramWData(swd[1]), .iSramRData(srd[1])
    );

    mem_responder #(.AW(12), .WAIT_STATES(4)) u_ws4 (
        .iClk(clk), .nRst(nrst[2]),
        .iMemIRead(ird[2]), .iMemDRead(drd[2]), .iMemDWrite(dwr[2]),
        .iAddrI(addr_i), .iAddrD(addr_d), .iWData(wdat),
        .oIns(ins[2]), .oRData(rdat[2]), .oRdy(rdy[2]), .oFault(flt[2]),
        .oSramCe(ce[2]), .oSramWe(we[2]), .oSramAddr(saddr[2]),
        .oSramWData(swd[2]), .iSramRData(srd[2])
    );

    // Synchronous SRAM model: registered read data holds until the next read.
    always @(posedge clk) begin
        if (pl_vld) mem[pl_k][pl_a] <= pl_d;
        for (int k = 0; k < 3; k++) begin
            if (ce[k]) begin
                if (we[k]) mem[k][saddr[k]] <= swd[k];
                else       srd[k] <= mem[k][saddr[k]];
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int k, input logic [11:0] a, input logic [31:0] d);
        pl_vld = 1'b1; pl_k = k; pl_a = a; pl_d = d;
        tick();
        pl_vld = 1'b0;
    endtask

    // Counts cycles from now until rdy[k]; stops at budget so a stuck DUT fails the latency check.
    task automatic wait_rdy(input int k, input int budget, output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!rdy[k] && cyc < budget);
    endtask

    int lat;
    int ce_cyc  [$];
    int rdy_cyc [$];

    initial begin
        for (int k = 0; k < 3; k++) begin
            nrst[k] = 1'b0; ird[k] = 1'b0; drd[k] = 1'b0; dwr[k] = 1'b0;
        end
        addr_i = 32'd0; addr_d = 32'd0; wdat = 32'd0;
        pl_vld = 1'b0; pl_k = 0; pl_a = 12'd0; pl_d = 32'd0;
        #2;

        // Reset state
        check("rst_ins",   ins[0],  32'd0);
        check("rst_rdata", rdat[0], 32'd0);
        check("rst_rdy",   rdy[0],  32'd0);
        check("rst_fault", flt[0],  32'd0);
        check("rst_ce",    ce[0],   32'd0);
        check("rst_we",    we[0],   32'd0);
        check("rst_addr",  32'(saddr[0]), 32'd0);
        check("rst_wdata", swd[0],  32'd0);

        preload(0, 12'h010, 32'hDEADBEEF);
        preload(0, 12'h020, 32'hCAFEF00D);
        preload(0, 12'h003, 32'hA5A50003);
        preload(1, 12'h005, 32'h11112222);
        preload(1, 12'h006, 32'h33334444);
        preload(2, 12'h000, 32'h77778888);
        for (int k = 0; k < 3; k++) nrst[k] = 1'b1;
        tick();

        // Basic fetch, WAIT_STATES=1: ACCESS in cycle 1, oRdy in cycle 3
        ird[0] = 1'b1; addr_i = 32'h40;
        tick();
        check("f1_ce_c1",   ce[0], 32'd1);
        check("f1_addr_c1", 32'(saddr[0]), 32'h10);
        check("f1_we_c1",   we[0], 32'd0);
        check("f1_rdy_c1",  rdy[0], 32'd0);
        tick();
        check("f1_ce_c2",   ce[0], 32'd0);
        check("f1_rdy_c2",  rdy[0], 32'd0);
        tick();
        check("f1_rdy_c3",  rdy[0], 32'd1);
        check("f1_fault_c3", flt[0], 32'd0);
        check("f1_ins_c3",  ins[0], 32'hDEADBEEF);
        ird[0] = 1'b0;
        tick();
        check("f1_rdy_pulse", rdy[0], 32'd0);

        // Write then read back
        dwr[0] = 1'b1; addr_d = 32'h8; wdat = 32'h12345678;
        tick();
        check("wr_ce",    ce[0], 32'd1);
        check("wr_we",    we[0], 32'd1);
        check("wr_addr",  32'(saddr[0]), 32'h2);
        check("wr_wdata", swd[0], 32'h12345678);
        tick();
        check("wr_we_wait", we[0], 32'd0);
        tick();
        check("wr_rdy",   rdy[0], 32'd1);
        check("wr_ins",   ins[0], 32'hDEADBEEF);
        check("wr_rdata", rdat[0], 32'd0);
        dwr[0] = 1'b0; wdat = 32'h0;
        tick();
        drd[0] = 1'b1; addr_d = 32'h8;
        wait_rdy(0, 20, lat);
        check("rd_lat",   32'(lat), 32'd3);
        check("rd_rdata", rdat[0], 32'h12345678);
        check("rd_ins",   ins[0], 32'hDEADBEEF);
        drd[0] = 1'b0;
        tick();

        // Simultaneous fetch and data read: data first, fetch 4 cycles after
        ird[0] = 1'b1; addr_i = 32'h80;
        drd[0] = 1'b1; addr_d = 32'hC;
        wait_rdy(0, 20, lat);
        check("pri_d_lat",   32'(lat), 32'd3);
        check("pri_d_rdata", rdat[0], 32'hA5A50003);
        check("pri_d_ins",   ins[0], 32'hDEADBEEF);
        drd[0] = 1'b0;
        wait_rdy(0, 20, lat);
        check("pri_f_lat",   32'(lat), 32'd4);
        check("pri_f_ins",   ins[0], 32'hCAFEF00D);
        check("pri_f_rdata", rdat[0], 32'hA5A50003);
        ird[0] = 1'b0;
        tick();

        // Misaligned data read
        drd[0] = 1'b1; addr_d = 32'h6;
        tick();
        check("mis_rdy",   rdy[0], 32'd1);
        check("mis_fault", flt[0], 32'd1);
        check("mis_ce",    ce[0], 32'd0);
        check("mis_rdata", rdat[0], 32'hA5A50003);
        drd[0] = 1'b0;
        tick();
        check("mis_rdy_clr",   rdy[0], 32'd0);
        check("mis_fault_clr", flt[0], 32'd0);
        check("mis_ce_after",  ce[0], 32'd0);

        // Read and write both high: illegal, memory untouched
        drd[0] = 1'b1; dwr[0] = 1'b1; addr_d = 32'h8; wdat = 32'hFFFFFFFF;
        tick();
        check("rw_fault", flt[0], 32'd1);
        check("rw_rdy",   rdy[0], 32'd1);
        check("rw_we",    we[0], 32'd0);
        drd[0] = 1'b0; dwr[0] = 1'b0;
        tick();
        check("rw_mem",   mem[0][2], 32'h12345678);

        // Misaligned fetch
        ird[0] = 1'b1; addr_i = 32'h41;
        tick();
        check("mif_fault", flt[0], 32'd1);
        check("mif_ins",   ins[0], 32'hCAFEF00D);
        ird[0] = 1'b0;
        tick();

        // High address bits ignored; request and address dropped after latch
        ird[0] = 1'b1; addr_i = 32'h0000_4040;
        tick();
        check("hi_addr", 32'(saddr[0]), 32'h010);
        ird[0] = 1'b0; addr_i = 32'h80;
        tick();
        check("hi_addr_hold", 32'(saddr[0]), 32'h010);
        tick();
        check("drop_rdy", rdy[0], 32'd1);
        check("drop_ins", ins[0], 32'hDEADBEEF);
        tick();

        // WAIT_STATES=3: normal fetch, then reset during WAIT
        ird[1] = 1'b1; addr_i = 32'h14;
        wait_rdy(1, 20, lat);
        check("ws3_lat", 32'(lat), 32'd5);
        check("ws3_ins", ins[1], 32'h11112222);
        ird[1] = 1'b0;
        tick();
        ird[1] = 1'b1; addr_i = 32'h18;
        tick();
        check("ws3_ce", ce[1], 32'd1);
        ird[1] = 1'b0;
        tick();
        #2;
        nrst[1] = 1'b0;
        #1;
        check("arst_ins",   ins[1], 32'd0);
        check("arst_ce",    ce[1], 32'd0);
        check("arst_we",    we[1], 32'd0);
        check("arst_addr",  32'(saddr[1]), 32'd0);
        check("arst_rdy",   rdy[1], 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("arst_no_rdy", rdy[1], 32'd0);
        end
        nrst[1] = 1'b1;
        ird[1] = 1'b1; addr_i = 32'h18;
        wait_rdy(1, 20, lat);
        check("post_rst_lat", 32'(lat), 32'd5);
        check("post_rst_ins", ins[1], 32'h33334444);
        ird[1] = 1'b0;
        tick();

        // WAIT_STATES=4: held fetch repeats every 7 cycles
        ird[2] = 1'b1; addr_i = 32'h0;
        for (int c = 1; c <= 21; c++) begin
            tick();
            if (ce[2])  ce_cyc.push_back(c);
            if (rdy[2]) rdy_cyc.push_back(c);
        end
        ird[2] = 1'b0;
        check("b2b_ce_cnt",  32'(ce_cyc.size()), 32'd3);
        check("b2b_rdy_cnt", 32'(rdy_cyc.size()), 32'd3);
        if (ce_cyc.size() == 3 && rdy_cyc.size() == 3) begin
            check("b2b_rdy0", 32'(rdy_cyc[0]), 32'd6);
            check("b2b_int1", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'd7);
            check("b2b_int2", 32'(rdy_cyc[2] - rdy_cyc[1]), 32'd7);
            for (int t = 0; t < 3; t++)
                check("b2b_ce_to_rdy", 32'(rdy_cyc[t] - ce_cyc[t]), 32'd5);
        end
        check("b2b_ins", ins[2], 32'h77778888);
        tick();
        check("b2b_idle", ce[2], 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
